gray_counter: RTL and testbench

Parametrised synchronous up/down counter that holds its state in both binary and Gray form, each in its own register.
- Supports parallel load in either code, with one-cycle latency.
- Flags terminal counts and reports wrap-around.
- Intended as the pointer and sequence generator for FIFO and CDC logic: gray_out is a glitch-free register output that is safe to hand to a synchroniser.

---
 rtl/gray_pkg.sv | 25 ++
 rtl/gray_counter_if.sv | 29 ++
 rtl/gray_counter_next.sv | 49 ++++
 rtl/gray_counter.sv | 57 +++++
 tb/tb_gray_counter.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/gray_pkg.sv
// Shared types and binary/Gray conversion helpers for the gray counter slice.
// Latency: none (types and pure functions only).
// Backpressure: not applicable.
package gray_pkg;

  typedef enum logic {DIR_DOWN = 1'b0, DIR_UP = 1'b1} dir_e;

  localparam int MAX_W = 32;

  // Callers zero-extend narrower values and truncate the result back to N.
  function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Each binary bit is the XOR of all Gray bits at or above it.
  function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] g);
    logic [MAX_W-1:0] b;
    b[MAX_W-1] = g[MAX_W-1];
    for (int i = MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_counter_if.sv
// Control and status bundle between a gray_counter and its user.
// Latency: none (wires only).
// Backpressure: none; the counter accepts a command every cycle.
interface gray_counter_if #(
  parameter int N = 4
) ();

  logic         en;
  logic         dir;
  logic         load;
  logic         load_is_gray;
  logic [N-1:0] load_val;
  logic [N-1:0] bin_out;
  logic [N-1:0] gray_out;
  logic         tc_up;
  logic         tc_dn;
  logic         wrap;

  modport master (
    output en, dir, load, load_is_gray, load_val,
    input  bin_out, gray_out, tc_up, tc_dn, wrap
  );

  modport slave (
    input  en, dir, load, load_is_gray, load_val,
    output bin_out, gray_out, tc_up, tc_dn, wrap
  );

endinterface

// File: rtl/gray_counter_next.sv
// Next-state generator: load value (either code) or one up/down step, plus wrap event.
// Latency: purely combinational.
// Backpressure: none.
module gray_counter_next
  import gray_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0] bin_q,
  input  dir_e         dir,
  input  logic         load,
  input  logic         load_is_gray,
  input  logic [N-1:0] load_val,
  output logic [N-1:0] bin_nxt,
  output logic [N-1:0] gray_nxt,
  output logic         wrap_evt
);

  logic [N-1:0]     step_bin;
  logic [MAX_W-1:0] ld_ext;
  logic [MAX_W-1:0] ld_as_bin;
  logic [MAX_W-1:0] ld_as_gray;
  logic [MAX_W-1:0] step_gray;

  // N-bit truncating arithmetic gives the modulo-2**N wrap for free.
  assign step_bin   = (dir == DIR_UP) ? bin_q + N'(1) : bin_q - N'(1);
  assign ld_ext     = MAX_W'(load_val);
  assign ld_as_bin  = gray2bin(ld_ext);
  assign ld_as_gray = bin2gray(ld_ext);
  assign step_gray  = bin2gray(MAX_W'(step_bin));

  // Load wins over stepping; a load never reports a wrap, whatever value it lands on.
  always_comb begin
    bin_nxt  = step_bin;
    gray_nxt = step_gray[N-1:0];
    wrap_evt = (dir == DIR_UP) ? (&bin_q) : ~(|bin_q);
    if (load) begin
      wrap_evt = 1'b0;
      if (load_is_gray) begin
        bin_nxt  = ld_as_bin[N-1:0];
        gray_nxt = load_val;
      end else begin
        bin_nxt  = load_val;
        gray_nxt = ld_as_gray[N-1:0];
      end
    end
  end

endmodule

// File: rtl/gray_counter.sv
// Up/down counter keeping binary and Gray copies in separate flops; parallel load in either code.
// Latency: one cycle from load/en to bin_out, gray_out and wrap; tc_up/tc_dn decode bin_q directly.
// Backpressure: none; every cycle's command is applied.
module gray_counter
  import gray_pkg::*;
#(
  parameter int           N       = 4,
  parameter logic [N-1:0] RST_VAL = '0
) (
  input logic          clk,
  input logic          rst,
  gray_counter_if.slave bus
);

  localparam logic [MAX_W-1:0] RST_GRAY_EXT = bin2gray(MAX_W'(RST_VAL));
  localparam logic [N-1:0]     RST_GRAY     = RST_GRAY_EXT[N-1:0];

  logic [N-1:0] bin_q;
  logic [N-1:0] gray_q;
  logic         wrap_q;
  logic [N-1:0] bin_nxt;
  logic [N-1:0] gray_nxt;
  logic         wrap_evt;

  gray_counter_next #(.N(N)) u_next (
    .bin_q        (bin_q),
    .dir          (dir_e'(bus.dir)),
    .load         (bus.load),
    .load_is_gray (bus.load_is_gray),
    .load_val     (bus.load_val),
    .bin_nxt      (bin_nxt),
    .gray_nxt     (gray_nxt),
    .wrap_evt     (wrap_evt)
  );

  // Priority rst > load > en > hold; gray_q is its own flop so gray_out never glitches.
  always_ff @(posedge clk) begin
    if (rst) begin
      bin_q  <= RST_VAL;
      gray_q <= RST_GRAY;
      wrap_q <= 1'b0;
    end else if (bus.load || bus.en) begin
      bin_q  <= bin_nxt;
      gray_q <= gray_nxt;
      wrap_q <= wrap_evt;
    end else begin
      wrap_q <= 1'b0;
    end
  end

  assign bus.bin_out  = bin_q;
  assign bus.gray_out = gray_q;
  assign bus.wrap     = wrap_q;
  assign bus.tc_up    = &bin_q;
  assign bus.tc_dn    = ~(|bin_q);

endmodule

// File: tb/tb_gray_counter.sv
// Directed and randomised check of gray_counter at N=4 and N=8 against an integer reference model.
// Latency: model state advances once per rising edge; outputs are sampled 1 time unit later.
// Backpressure: not applicable.
module tb_gray_counter;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  gray_counter_if #(.N(4)) if4 ();
  gray_counter_if #(.N(8)) if8 ();

  gray_counter #(.N(4), .RST_VAL(4'd0)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (if4.slave)
  );

  gray_counter #(.N(8), .RST_VAL(8'd200)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (if8.slave)
  );

  int         n_cmp = 0;
  int         n_err = 0;
  int         m4 = 0;
  int         m8 = 0;
  bit         w4 = 1'b0;
  bit         w8 = 1'b0;
  logic [3:0] pg4 = '0;
  logic [7:0] pg8 = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Gray code by definition: adjacent integers differ in one bit.
  function automatic int g_of(input int b);
    return b ^ (b >> 1);
  endfunction

  // Inverse found by search over the whole code space rather than by a bit recurrence.
  function automatic int g_inv(input int n, input int g);
    for (int x = 0; x < (1 << n); x++) begin
      if (g_of(x) == g) return x;
    end
    return -1;
  endfunction

  function automatic void mstep(input int n, input int rv, input bit r, input bit ld,
                                input bit lg, input int lv, input bit e, input bit d,
                                input int b, output int nb, output bit nw);
    int modv;
    modv = 1 << n;
    nb = b;
    nw = 1'b0;
    if (r) begin
      nb = rv;
    end else if (ld) begin
      nb = lg ? g_inv(n, lv) : lv;
    end else if (e) begin
      if (d) begin
        nb = (b + 1) % modv;
        nw = (b == modv - 1);
      end else begin
        nb = (b + modv - 1) % modv;
        nw = (b == 0);
      end
    end
  endfunction

  task automatic tick(input bit r, input bit ld, input bit lg, input logic [7:0] lv,
                      input bit e, input bit d);
    int nb;
    bit nw;
    rst = r;
    if4.load = ld; if4.load_is_gray = lg; if4.load_val = lv[3:0]; if4.en = e; if4.dir = d;
    if8.load = ld; if8.load_is_gray = lg; if8.load_val = lv;      if8.en = e; if8.dir = d;
    @(posedge clk);
    #1;
    mstep(4, 0, r, ld, lg, int'(lv[3:0]), e, d, m4, nb, nw);
    m4 = nb; w4 = nw;
    mstep(8, 200, r, ld, lg, int'(lv), e, d, m8, nb, nw);
    m8 = nb; w8 = nw;

    chk("bin4",  32'(if4.bin_out),  32'(m4));
    chk("gray4", 32'(if4.gray_out), 32'(g_of(m4)));
    chk("wrap4", 32'(if4.wrap),     32'(w4));
    chk("tcup4", 32'(if4.tc_up),    32'(m4 == 15));
    chk("tcdn4", 32'(if4.tc_dn),    32'(m4 == 0));
    chk("bin8",  32'(if8.bin_out),  32'(m8));
    chk("gray8", 32'(if8.gray_out), 32'(g_of(m8)));
    chk("wrap8", 32'(if8.wrap),     32'(w8));
    chk("tcup8", 32'(if8.tc_up),    32'(m8 == 255));
    chk("tcdn8", 32'(if8.tc_dn),    32'(m8 == 0));
    if (!r && !ld) begin
      chk("ham4", 32'($countones(pg4 ^ if4.gray_out)), e ? 32'd1 : 32'd0);
      chk("ham8", 32'($countones(pg8 ^ if8.gray_out)), e ? 32'd1 : 32'd0);
    end
    pg4 = if4.gray_out;
    pg8 = if8.gray_out;
  endtask

  initial begin
    int exp_bin[3]  = '{0, 15, 14};
    int exp_gray[3] = '{0, 8, 9};
    int exp_wrap[3] = '{0, 1, 0};

    // Reset for two cycles.
    tick(1, 0, 0, 8'd0, 0, 0);
    tick(1, 0, 0, 8'd0, 0, 0);
    chk("rst_bin4",  32'(if4.bin_out),  32'd0);
    chk("rst_gray4", 32'(if4.gray_out), 32'd0);
    chk("rst_wrap4", 32'(if4.wrap),     32'd0);
    chk("rst_tcup4", 32'(if4.tc_up),    32'd0);
    chk("rst_tcdn4", 32'(if4.tc_dn),    32'd1);
    chk("rst_bin8",  32'(if8.bin_out),  32'd200);

    // Twenty up-steps from zero: wraps once, after 15 -> 0.
    for (int i = 0; i < 20; i++) begin
      tick(0, 0, 0, 8'd0, 1, 1);
      chk("up_bin",  32'(if4.bin_out), 32'((i + 1) % 16));
      chk("up_wrap", 32'(if4.wrap),    32'(i == 15));
    end

    // Load binary 1 then count down across zero.
    tick(0, 1, 0, 8'd1, 0, 0);
    chk("ld1_gray", 32'(if4.gray_out), 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick(0, 0, 0, 8'd0, 1, 0);
      chk("dn_bin",  32'(if4.bin_out),  32'(exp_bin[i]));
      chk("dn_gray", 32'(if4.gray_out), 32'(exp_gray[i]));
      chk("dn_wrap", 32'(if4.wrap),     32'(exp_wrap[i]));
    end

    // Gray-coded load of 1101 is binary 9; one up-step gives 10 / 1111.
    tick(0, 1, 1, 8'b0000_1101, 0, 0);
    chk("gld_bin",  32'(if4.bin_out),  32'd9);
    chk("gld_gray", 32'(if4.gray_out), 32'b1101);
    tick(0, 0, 0, 8'd0, 1, 1);
    chk("gld_up_bin",  32'(if4.bin_out),  32'd10);
    chk("gld_up_gray", 32'(if4.gray_out), 32'b1111);

    // Load together with en: only the load lands.
    tick(0, 1, 0, 8'd5, 1, 1);
    chk("ld_en_bin", 32'(if4.bin_out), 32'd5);

    // Hold for five cycles.
    for (int i = 0; i < 5; i++) begin
      tick(0, 0, 0, 8'hA5, 0, 1);
      chk("hold_bin",  32'(if4.bin_out), 32'd5);
      chk("hold_wrap", 32'(if4.wrap),    32'd0);
    end

    // Loading the wrap target does not raise wrap.
    tick(0, 1, 0, 8'd15, 0, 0);
    tick(0, 1, 0, 8'd0, 1, 1);
    chk("ld_nowrap", 32'(if4.wrap), 32'd0);

    // Reset beats a simultaneous load.
    tick(1, 1, 0, 8'd7, 1, 1);
    chk("rst_ld_bin4", 32'(if4.bin_out), 32'd0);
    chk("rst_ld_bin8", 32'(if8.bin_out), 32'd200);

    // Randomised run.
    for (int i = 0; i < 10000; i++) begin
      tick(bit'($urandom_range(0, 63) == 0),
           bit'($urandom_range(0, 7) == 0),
           bit'($urandom_range(0, 1)),
           8'($urandom),
           bit'($urandom_range(0, 3) != 0),
           bit'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
